// File: rtl/alu_lock_pkg.sv
// Shared definitions for the locked ALU and its key loader.
// Holds the loader FSM states, key width, ALU opcodes and known-answer test values.
package alu_lock_pkg;

    localparam int KEY_W = 8;

    // ALU opcodes; the ALU decoder uses the same encoding
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;

    // Known-answer check: A op B must equal EXP under the right key
    localparam logic [31:0] CHK_A   = 32'd7;
    localparam logic [31:0] CHK_B   = 32'd5;
    localparam logic [31:0] CHK_EXP = 32'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_VERIFY_DRIVE,
        ST_VERIFY_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } kl_state_e;

endpackage

// File: rtl/alu_key_shifter.sv
// Serial key frame receiver: MSB-first shift register, bit counter, restart.
// Ports: clear restarts a frame, en gates bit capture, bit_valid/bit_in serial
// input; frame_done pulses one cycle after the last frame bit, word holds the
// received key bits. Macro ALU_KEY_LOADER_PARITY_EN adds a 9th odd-parity bit
// per frame and a par_err output valid with frame_done.
module alu_key_shifter #(
    parameter int KEY_W = alu_lock_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             frame_done,
`ifdef ALU_KEY_LOADER_PARITY_EN
    output logic             par_err,
`endif
    output logic [KEY_W-1:0] word
);

`ifdef ALU_KEY_LOADER_PARITY_EN
    localparam int FRAME_W = KEY_W + 1;
`else
    localparam int FRAME_W = KEY_W;
`endif
    localparam int CW = $clog2(FRAME_W + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] FULL = CW'(FRAME_W);

    logic [FRAME_W-1:0] shreg;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (en && bit_valid && cnt != FULL) begin
                shreg <= {shreg[FRAME_W-2:0], bit_in};
                cnt   <= cnt + CW'(1);
                if (cnt == LAST) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_KEY_LOADER_PARITY_EN
    // Key bits arrive first, parity bit last; odd parity => XOR of all is 1
    assign word    = shreg[FRAME_W-1:1];
    assign par_err = ~(^shreg);
`else
    assign word = shreg;
`endif

endmodule

// File: rtl/alu_key_loader.sv
// Key-provisioning controller: unmasks a serial key, proves it on the ALU.
// Ports: kl_start/kl_bit_valid/kl_bit serial key frame in; alu_result from ALU;
// alu_a/alu_b/alu_op/alu_sel drive the ALU during verification; key to ALU;
// unlocked, lockout, fail_cnt, busy status. Macro ALU_KEY_LOADER_PARITY_EN
// adds a parity bit per frame and the parity_err pulse output.
module alu_key_loader #(
    parameter int               KEY_W        = alu_lock_pkg::KEY_W,
    parameter logic [KEY_W-1:0] KEY_MASK     = KEY_W'(8'hA5),
    parameter logic [31:0]      CHK_A        = alu_lock_pkg::CHK_A,
    parameter logic [31:0]      CHK_B        = alu_lock_pkg::CHK_B,
    parameter logic [3:0]       CHK_OP       = alu_lock_pkg::OP_ADD,
    parameter logic [31:0]      CHK_EXP      = alu_lock_pkg::CHK_EXP,
    parameter int               MAX_ATTEMPTS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kl_start,
    input  logic             kl_bit_valid,
    input  logic             kl_bit,
    input  logic [31:0]      alu_result,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_sel,
    output logic [KEY_W-1:0] key,
    output logic             unlocked,
    output logic             lockout,
    output logic [1:0]       fail_cnt,
`ifdef ALU_KEY_LOADER_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    import alu_lock_pkg::*;

    localparam logic [1:0] MAX_CNT = 2'(MAX_ATTEMPTS);

    kl_state_e        state;
    logic             sh_clear;
    logic             sh_en;
    logic             frame_done;
    logic [KEY_W-1:0] sh_word;
    logic [1:0]       fail_next;
`ifdef ALU_KEY_LOADER_PARITY_EN
    logic             sh_perr;
`endif

    // kl_start is honoured everywhere except VERIFY_* and LOCKOUT
    assign sh_clear = kl_start &&
                      (state == ST_IDLE  ||
                       state == ST_SHIFT ||
                       state == ST_UNLOCKED);
    assign sh_en    = (state == ST_SHIFT);

    // Saturating: the count never moves past the lockout threshold
    assign fail_next = (fail_cnt == MAX_CNT) ? fail_cnt : fail_cnt + 2'd1;

    alu_key_shifter #(
        .KEY_W      (KEY_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (sh_clear),
        .en         (sh_en),
        .bit_valid  (kl_bit_valid),
        .bit_in     (kl_bit),
        .frame_done (frame_done),
`ifdef ALU_KEY_LOADER_PARITY_EN
        .par_err    (sh_perr),
`endif
        .word       (sh_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            alu_sel  <= 1'b0;
            key      <= '0;
            unlocked <= 1'b0;
            lockout  <= 1'b0;
            fail_cnt <= '0;
            busy     <= 1'b0;
`ifdef ALU_KEY_LOADER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
`ifdef ALU_KEY_LOADER_PARITY_EN
            parity_err <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (kl_start) begin
                        state <= ST_SHIFT;
                        busy  <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    // A restart takes priority over a just-completed frame
                    if (!kl_start && frame_done) begin
`ifdef ALU_KEY_LOADER_PARITY_EN
                        if (sh_perr) begin
                            parity_err <= 1'b1;
                            fail_cnt   <= fail_next;
                            busy       <= 1'b0;
                            if (fail_next == MAX_CNT) begin
                                state   <= ST_LOCKOUT;
                                lockout <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
`endif
                            state   <= ST_VERIFY_DRIVE;
                            alu_sel <= 1'b1;
                            alu_a   <= CHK_A;
                            alu_b   <= CHK_B;
                            alu_op  <= CHK_OP;
                            key     <= sh_word ^ KEY_MASK;
`ifdef ALU_KEY_LOADER_PARITY_EN
                        end
`endif
                    end
                end

                // Gives the ALU a full cycle to settle on the candidate key
                ST_VERIFY_DRIVE: begin
                    state <= ST_VERIFY_CHECK;
                end

                ST_VERIFY_CHECK: begin
                    alu_sel <= 1'b0;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    alu_op  <= '0;
                    busy    <= 1'b0;
                    if (alu_result == CHK_EXP) begin
                        state    <= ST_UNLOCKED;
                        unlocked <= 1'b1;
                    end else begin
                        key      <= '0;
                        fail_cnt <= fail_next;
                        if (fail_next == MAX_CNT) begin
                            state   <= ST_LOCKOUT;
                            lockout <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                // Re-provisioning drops the proven key at once
                ST_UNLOCKED: begin
                    if (kl_start) begin
                        state    <= ST_SHIFT;
                        unlocked <= 1'b0;
                        key      <= '0;
                        busy     <= 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    state <= ST_LOCKOUT;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_key_loader.sv
// Scoreboard bench for alu_key_loader with a behavioural ALU that unlocks at 8'h26.
// Stimulus pushes expected outcomes per frame; a monitor checks each completed verify.
module tb_alu_key_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kl_start = 1'b0;
    logic        kl_bit_valid = 1'b0;
    logic        kl_bit = 1'b0;
    logic [31:0] alu_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_sel;
    logic [7:0]  key;
    logic        unlocked;
    logic        lockout;
    logic [1:0]  fail_cnt;
    logic        busy;

    alu_key_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kl_start     (kl_start),
        .kl_bit_valid (kl_bit_valid),
        .kl_bit       (kl_bit),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_sel      (alu_sel),
        .key          (key),
        .unlocked     (unlocked),
        .lockout      (lockout),
        .fail_cnt     (fail_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Locked ALU: correct only when the key is 8'h26, scrambled otherwise
    always_comb begin
        alu_result = '0;
        if (key == 8'h26) begin
            case (alu_op)
                4'b0000: alu_result = alu_a + alu_b;
                4'b0001: alu_result = alu_a - alu_b;
                4'b0010: alu_result = alu_a & alu_b;
                4'b0011: alu_result = alu_a | alu_b;
                default: alu_result = alu_a ^ alu_b;
            endcase
        end else begin
            alu_result = (alu_a + alu_b) ^ 32'hFFFF_0000 ^ {24'd0, key};
        end
    end

    typedef struct packed {
        logic       unl;
        logic       lock;
        logic [1:0] fc;
        logic [7:0] key;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_edge = 0;
    bit   m_unl = 0;
    bit   m_lock = 0;
    int   m_fails = 0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: one frame either proves key 8'h26 or costs an attempt
    task automatic model_push(input logic [7:0] w);
        exp_t e;
        if (m_lock) return;
        m_unl = 0;
        if ((w ^ 8'hA5) == 8'h26) begin
            m_unl = 1;
        end else begin
            m_fails++;
            if (m_fails >= 3) m_lock = 1;
        end
        e.unl  = m_unl;
        e.lock = m_lock;
        e.fc   = 2'(m_fails);
        e.key  = m_unl ? 8'h26 : 8'h00;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done expected none at cycle %0d",
                             cyc);
                end else begin
                    e = q.pop_front();
                    check("unlocked", {31'd0, unlocked}, {31'd0, e.unl});
                    check("lockout", {31'd0, lockout}, {31'd0, e.lock});
                    check("fail_cnt", {30'd0, fail_cnt}, {30'd0, e.fc});
                    check("key", {24'd0, key}, {24'd0, e.key});
                    check("alu_sel_after", {31'd0, alu_sel}, 32'd0);
                    check("latency", cyc - last_edge, 32'd3);
                end
            end
            prev_busy = busy;
        end
    end

    // All tasks start and end at posedge + 1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        kl_start = 1'b1;
        tick();
        kl_start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    kl_bit_valid = 1'b0;
                    kl_bit = 1'($urandom);
                    tick();
                end
            end
            kl_bit_valid = 1'b1;
            kl_bit = w[7-i];
            last_edge = cyc + 1;
            tick();
        end
        kl_bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input bit gaps);
        model_push(w);
        pulse_start();
        send_bits(w, 8, gaps);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        m_unl = 0;
        m_lock = 0;
        m_fails = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_key"}, {24'd0, key}, 32'd0);
        check({tag, "_alu_sel"}, {31'd0, alu_sel}, 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_unlocked"}, {31'd0, unlocked}, 32'd0);
        check({tag, "_lockout"}, {31'd0, lockout}, 32'd0);
        check({tag, "_fail_cnt"}, {30'd0, fail_cnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        repeat (2) tick();
        check_zero("reset");
        check("reset_alu_b", alu_b, 32'd0);
        check("reset_alu_op", {28'd0, alu_op}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Correct key
        send_frame(8'h83, 1'b0);
        wait_drain();
        repeat (3) tick();
        check("unl_hold_key", {24'd0, key}, 32'h26);
        check("unl_alu_a", alu_a, 32'd0);

        // Re-provision from UNLOCKED, then a wrong frame
        model_push(8'h00);
        pulse_start();
        check("reprov_key", {24'd0, key}, 32'd0);
        check("reprov_unlocked", {31'd0, unlocked}, 32'd0);
        check("reprov_busy", {31'd0, busy}, 32'd1);
        send_bits(8'h00, 8, 1'b0);
        wait_drain();

        // Partial frame discarded by a restart
        pulse_start();
        send_bits(8'h00, 4, 1'b0);
        send_frame(8'h83, 1'b0);
        wait_drain();

        // Reset during VERIFY_CHECK
        pulse_start();
        send_bits(8'h83, 8, 1'b0);
        tick();
        check("vdrive_sel", {31'd0, alu_sel}, 32'd1);
        check("vdrive_key", {24'd0, key}, 32'h26);
        check("vdrive_a", alu_a, 32'd7);
        check("vdrive_b", alu_b, 32'd5);
        check("vdrive_op", {28'd0, alu_op}, 32'd0);
        tick();
        check("vcheck_sel", {31'd0, alu_sel}, 32'd1);
        check("vcheck_a", alu_a, 32'd7);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        tick();
        rst_n = 1'b1;
        m_unl = 0;
        m_lock = 0;
        m_fails = 0;
        send_frame(8'h83, 1'b0);
        wait_drain();

        // Two wrong frames, then the right one
        do_reset();
        send_frame(8'h00, 1'b0);
        wait_drain();
        send_frame(8'h5A, 1'b0);
        wait_drain();
        send_frame(8'h83, 1'b0);
        wait_drain();

        // Exhaust attempts
        do_reset();
        repeat (3) begin
            send_frame(8'h00, 1'b0);
            wait_drain();
        end
        send_frame(8'h83, 1'b0);
        repeat (6) tick();
        check("locked_key", {24'd0, key}, 32'd0);
        check("locked_lockout", {31'd0, lockout}, 32'd1);
        check("locked_unlocked", {31'd0, unlocked}, 32'd0);
        check("locked_busy", {31'd0, busy}, 32'd0);
        check("locked_fail_cnt", {30'd0, fail_cnt}, 32'd3);

        // Randomized frames with ignored noise between them
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if (m_lock) do_reset();
            repeat ($urandom_range(0, 3)) begin
                kl_bit_valid = 1'($urandom);
                kl_bit = 1'($urandom);
                tick();
            end
            kl_bit_valid = 1'b0;
            w = ($urandom_range(0, 1) == 0) ? 8'h83 : 8'($urandom);
            send_frame(w, 1'b1);
            wait_drain();
        end

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
